srl_fifo_16xm: RTL and testbench
================================

# srl_fifo_16xm

Synchronous FIFO built on 16-deep per-bit shift-register storage, with a registered first-word output stage and valid/ready read handshake. It is the read-side counterpart to the fixed-tap SRL delay line: data is pushed in by a producer and popped by a consumer on demand, with the tap address tracking the fill level. It is used wherever a DMB datapath needs shallow, SRL-mapped buffering between a bursty writer and a stalling reader.

## Interface
Parameters:
- Width, 16, data width in bits.
- AFULL_LVL, 14, LEVEL threshold for AFULL; meaningful only with SRL_FIFO_AFULL_EN.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous flush.
- WE  input  1  write request.
- DIN  input  Width  write data.
- FULL  output  1  SRL stage holds 16 words; writes are not accepted.
- RD  input  1  consumer ready; pops DOUT when DVALID=1.
- DOUT  output  Width  head-of-FIFO data, registered.
- DVALID  output  1  DOUT holds a valid word.
- LEVEL  output  5  total words held, 0..17: cnt + DVALID.
- OVF  output  1  sticky flag: write attempted while FULL.
- AFULL  output  1  almost-full flag; see Configuration.

## Operation
- Storage is sr[i][15:0] per bit, with no reset. An accepted write shifts DIN into bit 0.
- cnt (0..16) is the number of words in the SRL stage. The oldest word sits at tap cnt-1.
- A write is accepted when WE=1 and FULL=0. FULL is cnt==16, decoded from the registered cnt.
- pop = DVALID & RD.
- The output register loads when cnt>0 and (DVALID=0 or pop): DOUT <= sr[cnt-1], using pre-edge values, and DVALID <= 1.
- If pop occurs with cnt==0, DVALID <= 0 and DOUT holds its value.
- cnt next value:
  - cnt + accepted write − load.
  - Simultaneous write and load leaves cnt unchanged. The shift and the tap read use the pre-edge array, so order is preserved.
- Write when FULL:
  - Data is dropped, cnt is unchanged, OVF <= 1.
  - A simultaneous load still occurs, but the write is still refused because FULL was registered.
- CLR=1:
  - cnt <= 0, DVALID <= 0, OVF <= 0. DOUT holds.
  - WE and RD are ignored that cycle. Storage contents are not touched.
- Reset (RST_N=0, asynchronous): cnt=0, DVALID=0, DOUT=0, OVF=0. Hence FULL=0, LEVEL=0, AFULL=0.
- Reset mid-burst discards all contents. Behaviour after release is identical to power-up.

## Timing
- Write-to-valid latency into an empty FIFO:
  - Write accepted at edge N gives cnt=1.
  - Load at edge N+1 gives DVALID=1 and DOUT valid after N+1. Total: 2 cycles.
- Sustained throughput is 1 word/cycle in both directions with RD held high and the FIFO non-empty.
- DVALID deasserts the cycle after the last word is popped, if no word is pending in the SRL stage.
- DOUT and DVALID must stay stable while DVALID=1 and RD=0.
- LEVEL, FULL, OVF and AFULL are all registered-derived. None has a combinational path from WE or RD.
- Maximum capacity is 17 words: 16 in the SRL stage plus 1 in the output register.

## Configuration
- Macro: SRL_FIFO_AFULL_EN.
- Defined: AFULL is registered and equals 1 when the next-state LEVEL >= AFULL_LVL. It is 0 in reset and after CLR.
- Undefined: AFULL is tied to 0 and AFULL_LVL is unused. No extra registers are built.

## Test plan
- Reset, then a single write of 16'hA5A5 with RD=0 → DVALID=1 two cycles later, DOUT=16'hA5A5, LEVEL=1.
- Write 17 words 0..16 with RD=0 → FULL=1, LEVEL=17, OVF=0. Then RD=1 for 17 cycles → DOUT sequence 0..16, DVALID=0 afterwards, LEVEL=0.
- With the FIFO full, WE=1 and DIN=16'hDEAD → OVF=1, LEVEL stays 17, 16'hDEAD never appears on DOUT. CLR → OVF=0, LEVEL=0.
- Streaming with WE=1 and RD=1 for 100 cycles, incrementing data → DOUT increments by 1 every cycle after the 2-cycle fill, LEVEL constant at 2.
- Random WE/RD at 50% each for 10k cycles against a scoreboard model → no loss, reorder or duplication, and LEVEL matches the model each cycle.
- With SRL_FIFO_AFULL_EN and AFULL_LVL=14, write 13 then 1 more word → AFULL=0 at LEVEL=13 and AFULL=1 at LEVEL=14. Assert RST_N=0 asynchronously mid-test → all outputs 0 immediately.

Source files
------------

// File: rtl/srl_fifo_16xm_if.sv
// Producer/consumer bundle for srl_fifo_16xm: write side, read handshake and status flags.
interface srl_fifo_16xm_if #(
    parameter int Width = 16
);
    logic             CLR;
    logic             WE;
    logic [Width-1:0] DIN;
    logic             FULL;
    logic             RD;
    logic [Width-1:0] DOUT;
    logic             DVALID;
    logic [4:0]       LEVEL;
    logic             OVF;
    logic             AFULL;

    modport master (
        output CLR, WE, DIN, RD,
        input  FULL, DOUT, DVALID, LEVEL, OVF, AFULL
    );

    modport slave (
        input  CLR, WE, DIN, RD,
        output FULL, DOUT, DVALID, LEVEL, OVF, AFULL
    );
endinterface

// File: rtl/srl_fifo_16xm.sv
// 16-deep SRL-mapped FIFO with a registered first-word output stage (17 words total).
// Optional registered almost-full flag built only when SRL_FIFO_AFULL_EN is defined.
module srl_fifo_16xm #(
    parameter int Width     = 16,
    parameter int AFULL_LVL = 14
) (
    input  logic               CLK,
    input  logic               RST_N,
    srl_fifo_16xm_if.slave     f
);
    // Per-bit shift registers; no reset so they map onto SRL primitives.
    logic [15:0]      sr [Width];
    logic [4:0]       cnt, cnt_nxt;
    logic [3:0]       tap_idx;
    logic [Width-1:0] tap;
    logic [Width-1:0] dout_q;
    logic             dv_q, dv_nxt;
    logic             ovf_q;
    logic             full, wr_acc, pop, load;

    assign full    = (cnt == 5'd16);
    assign tap_idx = cnt[3:0] - 4'd1;
    assign wr_acc  = f.WE & ~full & ~f.CLR;
    assign pop     = dv_q & f.RD;
    assign load    = (cnt != 5'd0) & (~dv_q | pop) & ~f.CLR;

    for (genvar b = 0; b < Width; b++) begin : g_bit
        assign tap[b] = sr[b][tap_idx];
        always_ff @(posedge CLK) begin
            if (wr_acc) sr[b] <= {sr[b][14:0], f.DIN[b]};
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        dv_nxt  = dv_q;
        if (f.CLR) begin
            cnt_nxt = 5'd0;
            dv_nxt  = 1'b0;
        end else begin
            cnt_nxt = cnt + {4'd0, wr_acc} - {4'd0, load};
            if (load)     dv_nxt = 1'b1;
            else if (pop) dv_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= 5'd0;
            dv_q   <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            dv_q <= dv_nxt;
            if (load) dout_q <= tap;
            if (f.CLR)                ovf_q <= 1'b0;
            else if (f.WE && full)    ovf_q <= 1'b1;
        end
    end

`ifdef SRL_FIFO_AFULL_EN
    logic       afull_q;
    logic [4:0] lvl_nxt;
    assign lvl_nxt = cnt_nxt + {4'd0, dv_nxt};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     afull_q <= 1'b0;
        else if (f.CLR) afull_q <= 1'b0;
        else            afull_q <= (int'({27'd0, lvl_nxt}) >= AFULL_LVL);
    end
    assign f.AFULL = afull_q;
`else
    assign f.AFULL = 1'b0;
`endif

    assign f.FULL   = full;
    assign f.DOUT   = dout_q;
    assign f.DVALID = dv_q;
    assign f.LEVEL  = cnt + {4'd0, dv_q};
    assign f.OVF    = ovf_q;
endmodule

// File: tb/tb_srl_fifo_16xm.sv
// Random + directed bench for srl_fifo_16xm against a queue-based model of the FIFO.
module tb_srl_fifo_16xm;
    localparam int W  = 16;
    localparam int AL = 14;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    srl_fifo_16xm_if #(.Width(W)) bus ();
    srl_fifo_16xm #(.Width(W), .AFULL_LVL(AL)) dut (.CLK(CLK), .RST_N(RST_N), .f(bus));

    int nvec = 0;
    int nerr = 0;

    // Model: words waiting behind the head, plus the head register.
    logic [W-1:0] m_q[$];
    logic         m_dv   = 1'b0;
    logic [W-1:0] m_dout = '0;
    logic         m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_level();
        return 5'(m_q.size() + int'(m_dv));
    endfunction

    function automatic logic m_afull();
`ifdef SRL_FIFO_AFULL_EN
        return int'(m_level()) >= AL;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_q.delete();
            m_dv   = 1'b0;
            m_dout = '0;
            m_ovf  = 1'b0;
        end else if (bus.CLR) begin
            m_q.delete();
            m_dv  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            automatic bit was_full = (m_q.size() == 16);
            automatic bit p        = m_dv && bus.RD;
            if (m_q.size() > 0 && (!m_dv || p)) begin
                m_dout = m_q.pop_front();
                m_dv   = 1'b1;
            end else if (p) begin
                m_dv = 1'b0;
            end
            if (bus.WE) begin
                if (!was_full) m_q.push_back(bus.DIN);
                else           m_ovf = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("cyc_DVALID", 32'(bus.DVALID), 32'(m_dv));
            chk("cyc_DOUT",   32'(bus.DOUT),   32'(m_dout));
            chk("cyc_LEVEL",  32'(bus.LEVEL),  32'(m_level()));
            chk("cyc_FULL",   32'(bus.FULL),   32'(m_q.size() == 16));
            chk("cyc_OVF",    32'(bus.OVF),    32'(m_ovf));
            chk("cyc_AFULL",  32'(bus.AFULL),  32'(m_afull()));
        end
    end

    task automatic drive(input logic we, input logic [W-1:0] din, input logic rd, input logic clr);
        bus.WE  = we;
        bus.DIN = din;
        bus.RD  = rd;
        bus.CLR = clr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_DVALID"}, 32'(bus.DVALID), 32'd0);
        chk({tag, "_DOUT"},   32'(bus.DOUT),   32'd0);
        chk({tag, "_LEVEL"},  32'(bus.LEVEL),  32'd0);
        chk({tag, "_FULL"},   32'(bus.FULL),   32'd0);
        chk({tag, "_OVF"},    32'(bus.OVF),    32'd0);
        chk({tag, "_AFULL"},  32'(bus.AFULL),  32'd0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 chk_zero("reset");
        step();
        step();
        RST_N = 1'b1;

        // Single write: visible two edges later.
        drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("lat_dv_n", 32'(bus.DVALID), 32'd0);
        chk("lat_lvl_n", 32'(bus.LEVEL), 32'd1);
        step();
        @(negedge CLK);
        chk("lat_dv", 32'(bus.DVALID), 32'd1);
        chk("lat_dout", 32'(bus.DOUT), 32'hA5A5);
        chk("lat_lvl", 32'(bus.LEVEL), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("clr1_lvl", 32'(bus.LEVEL), 32'd0);

        // Fill to 17, overflow, drain in order.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_lvl", 32'(bus.LEVEL), 32'd17);
        chk("fill_ovf", 32'(bus.OVF), 32'd0);
        step();
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("ovf_set", 32'(bus.OVF), 32'd1);
        chk("ovf_lvl", 32'(bus.LEVEL), 32'd17);
        #1 drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            chk("drain_dv", 32'(bus.DVALID), 32'd1);
            chk("drain_dout", 32'(bus.DOUT), 32'(i));
            @(negedge CLK);
        end
        chk("drain_dv_end", 32'(bus.DVALID), 32'd0);
        chk("drain_lvl_end", 32'(bus.LEVEL), 32'd0);
        chk("ovf_sticky", 32'(bus.OVF), 32'd1);
        #1 drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, W'(16'h100 + i), 1'b0, 1'b0);
        end
        step();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("clr_ovf", 32'(bus.OVF), 32'd0);
        chk("clr_lvl", 32'(bus.LEVEL), 32'd0);

        // Streaming: level settles at 2, DOUT increments every cycle.
        step();
        drive(1'b1, 16'd1000, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            step();
            bus.DIN = W'(1000 + k + 1);
            @(negedge CLK);
            if (k >= 1) begin
                chk("strm_lvl", 32'(bus.LEVEL), 32'd2);
                chk("strm_dout", 32'(bus.DOUT), 32'(1000 + k - 1));
            end
        end
        #1 drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);

        // Almost-full threshold, then asynchronous reset while loaded.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, W'(16'h200 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        @(negedge CLK);
        chk("af13_lvl", 32'(bus.LEVEL), 32'd13);
        chk("af13_af", 32'(bus.AFULL), 32'd0);
        #1 drive(1'b1, 16'h20D, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("af14_lvl", 32'(bus.LEVEL), 32'd14);
`ifdef SRL_FIFO_AFULL_EN
        chk("af14_af", 32'(bus.AFULL), 32'd1);
`else
        chk("af14_af", 32'(bus.AFULL), 32'd0);
`endif
        #1 RST_N = 1'b0;
        #1 chk_zero("arst");
        #1 RST_N = 1'b1;

        // Random traffic: balanced, then write-heavy to exercise FULL/OVF.
        for (int c = 0; c < 12000; c++) begin
            step();
            drive(c < 10000 ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) != 0),
                  W'($urandom),
                  c < 10000 ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 199) == 0));
        end
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
